// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates two writeback requesters (A: ALU, B: load/mul-div) onto the
//   single register-file write port. An accepted request appears on the
//   registered write port one cycle later. Writes to rd==0 are accepted but
//   suppressed, because the zero register is never written.
//
// Build option:
//   WBARB_ROUND_ROBIN_EN  defined   -> round-robin between A and B; no
//                                      starvation counter; b_starved tied 0.
//                         undefined -> A has fixed priority, and B is
//                                      force-granted after STARVE_MAX
//                                      consecutive refusals.
//
// Ports:
//   clk, reset_n                 clock; async active-low reset
//   a_valid, a_rd, a_data        requester A request
//   a_ready                      A accepted this cycle (combinational)
//   b_valid, b_rd, b_data        requester B request
//   b_ready                      B accepted this cycle (combinational)
//   reg_write, rd, reg_in        registered register-file write port
//   b_starved                    B wait counter saturated (B wins next conflict)

module regfile_wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        reg_write,
  output logic [4:0]  rd,
  output logic [31:0] reg_in,
  output logic        b_starved
);

  logic        a_grant;
  logic        b_grant;
  logic        acc;
  logic [4:0]  acc_rd;
  logic [31:0] acc_data;
  logic        acc_wr;

`ifdef WBARB_ROUND_ROBIN_EN
  // prio_b = 1 means B was not the last requester granted, so B wins the
  // next conflict. The reset value favours A.
  logic prio_b;

  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    // Readies are gated by reset_n so nothing is offered while in reset.
    if (reset_n) begin
      if (a_valid && b_valid) begin
        a_grant = !prio_b;
        b_grant = prio_b;
      end else begin
        a_grant = a_valid;
        b_grant = b_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_b <= 1'b0;
    end else if (a_grant) begin
      prio_b <= 1'b1;
    end else if (b_grant) begin
      prio_b <= 1'b0;
    end
  end

  assign b_starved = 1'b0;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] wait_cnt;
  logic [3:0] wait_nxt;
  logic       force_b;

  assign force_b = (wait_cnt == STARVE_LIM);

  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (reset_n) begin
      if (a_valid && b_valid) begin
        a_grant = !force_b;
        b_grant = force_b;
      end else begin
        a_grant = a_valid;
        b_grant = b_valid;
      end
    end
  end

  // Counts consecutive cycles in which B waited. It saturates at the limit
  // and clears whenever B is served or withdraws.
  always_comb begin
    wait_nxt = 4'd0;
    if (b_valid && !b_grant) begin
      wait_nxt = force_b ? STARVE_LIM : wait_cnt + 4'd1;
    end
  end

  // b_starved is registered from the same next value, so it always mirrors
  // (wait_cnt == STARVE_MAX) without a combinational path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= 4'd0;
      b_starved <= 1'b0;
    end else begin
      wait_cnt  <= wait_nxt;
      b_starved <= (wait_nxt == STARVE_LIM);
    end
  end
`endif

  assign a_ready = a_grant;
  assign b_ready = b_grant;

  always_comb begin
    acc      = a_grant || b_grant;
    acc_rd   = b_grant ? b_rd : a_rd;
    acc_data = b_grant ? b_data : a_data;
    acc_wr   = acc && (acc_rd != 5'd0);
  end

  // The write port holds zeros in any cycle that does not carry a real write.
  // This covers idle cycles and accepted writes to the zero register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_write <= 1'b0;
      rd        <= 5'd0;
      reg_in    <= 32'd0;
    end else begin
      reg_write <= acc_wr;
      rd        <= acc_wr ? acc_rd : 5'd0;
      reg_in    <= acc_wr ? acc_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, b_valid;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] reg_in;
  logic        b_starved;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int          m_wait = 0;
  logic        p_we   = 1'b0;
  logic [4:0]  p_rd   = '0;
  logic [31:0] p_data = '0;
  string       glog   = "";

  regfile_wb_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .reg_write(reg_write), .rd(rd), .reg_in(reg_in), .b_starved(b_starved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  // Model: on every falling edge, check the outputs against the write the
  // model predicted. Then decide who wins the next rising edge from the
  // priority rule.
  initial begin
    logic ea, eb;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_reg_write", reg_write, 0);
        chk("rst_rd", rd, 0);
        chk("rst_reg_in", reg_in, 0);
        chk("rst_b_starved", b_starved, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        m_wait = 0;
        p_we = 0; p_rd = 0; p_data = 0;
      end else begin
        chk("m_reg_write", reg_write, p_we);
        chk("m_rd", rd, p_rd);
        chk("m_reg_in", reg_in, p_data);
        chk("m_b_starved", b_starved, m_wait == SM);
        ea = a_valid && !(b_valid && m_wait == SM);
        eb = b_valid && !ea;
        chk("m_a_ready", a_ready, ea);
        chk("m_b_ready", b_ready, eb);
        if (ea) glog = {glog, "A"};
        if (eb) glog = {glog, "B"};
        p_we = 0; p_rd = 0; p_data = 0;
        if (ea && a_rd != 0) begin p_we = 1; p_rd = a_rd; p_data = a_data; end
        if (eb && b_rd != 0) begin p_we = 1; p_rd = b_rd; p_data = b_data; end
        if (b_valid && !eb) m_wait = (m_wait + 1 > SM) ? SM : m_wait + 1;
        else m_wait = 0;
      end
    end
  end

  initial begin
    reset_n = 0;
    a_valid = 1; a_rd = 5'd4; a_data = 32'h55;
    b_valid = 0; b_rd = 0; b_data = 0;
    #1;
    chk("init_a_ready", a_ready, 0);
    chk("init_reg_write", reg_write, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1; a_valid = 0;

    // A alone, accepted in the same cycle and written one cycle later
    a_valid = 1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    #1 chk("a_only_ready", a_ready, 1);
    @(posedge clk); #1;
    chk("a_only_we", reg_write, 1);
    chk("a_only_rd", rd, 5);
    chk("a_only_data", reg_in, 32'hDEADBEEF);
    #1 a_valid = 0;

    // B to the zero register: accepted, but the write is suppressed
    b_valid = 1; b_rd = 5'd0; b_data = 32'h1234;
    #1 chk("b_rd0_ready", b_ready, 1);
    @(posedge clk); #1;
    chk("b_rd0_we", reg_write, 0);
    chk("b_rd0_rd", rd, 0);
    chk("b_rd0_data", reg_in, 0);
    #1 b_valid = 0;

    // Both valid continuously: A is granted 4 times, then B, and the pattern repeats
    glog = "";
    a_valid = 1; a_rd = 5'd1; a_data = 32'hA1;
    b_valid = 1; b_rd = 5'd2; b_data = 32'hB2;
    repeat (4) @(posedge clk);
    #1;
    chk("starve_flag", b_starved, 1);
    chk("starve_b_ready", b_ready, 1);
    chk("starve_a_ready", a_ready, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("starve_last_rd", rd, 2);
    chk("starve_last_data", reg_in, 32'hB2);
    chk_str("starve_pattern", glog, "AAAABAAAAB");
    #1 a_valid = 0; b_valid = 0;

    // B withdrawing clears the wait count
    glog = "";
    a_valid = 1; b_valid = 1;
    repeat (2) @(posedge clk);
    #2 b_valid = 0;
    @(posedge clk);
    #2 b_valid = 1;
    repeat (5) @(posedge clk);
    #1 chk_str("wait_clear_pattern", glog, "AAAAAAAB");
    #1 a_valid = 0; b_valid = 0;

    // Back-to-back writes to the same rd from A
    a_valid = 1; a_rd = 5'd9;
    for (int i = 1; i <= 3; i++) begin
      a_data = 32'h900 + 32'(i);
      @(posedge clk); #1;
      chk("waw_data", reg_in, 32'h900 + 32'(i));
      #1;
    end
    a_valid = 0;

    // Both requesters target rd=3; both writes land in acceptance order
    a_valid = 1; a_rd = 5'd3; a_data = 32'h1;
    b_valid = 1; b_rd = 5'd3; b_data = 32'h2;
    @(posedge clk); #1;
    chk("same_rd_first_rd", rd, 3);
    chk("same_rd_first", reg_in, 32'h1);
    #1 a_valid = 0;
    @(posedge clk); #1;
    chk("same_rd_second_rd", rd, 3);
    chk("same_rd_second", reg_in, 32'h2);
    #1 b_valid = 0;

    // Reset arriving while a write is on the port clears it immediately
    a_valid = 1; a_rd = 5'd7; a_data = 32'h77;
    @(posedge clk); #1;
    chk("inflight_we", reg_write, 1);
    #1 a_valid = 0; reset_n = 0;
    #1;
    chk("async_rst_we", reg_write, 0);
    chk("async_rst_rd", rd, 0);
    chk("async_rst_data", reg_in, 0);
    @(posedge clk); #2 reset_n = 1;
    @(posedge clk); #1;
    chk("post_rst_we", reg_write, 0);
    chk("post_rst_rd", rd, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, range 1..15: consecutive cycles B may be refused before a forced grant.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports a_valid in 1, a_rd in 5, a_data in 32: requester A (ALU writeback) request, destination, data.
REQ-005 SHALL have port a_ready  out  1  A request accepted this cycle.
REQ-006 SHALL have ports b_valid in 1, b_rd in 5, b_data in 32: requester B (load/mul-div writeback) request, destination, data.
REQ-007 SHALL have port b_ready  out  1  B request accepted this cycle.
REQ-008 SHALL have ports reg_write out 1, rd out 5, reg_in out 32: registered single write port into the register file.
REQ-009 SHALL have port b_starved  out  1  B wait counter saturated (forced grant pending).

Function
REQ-010 SHALL transfer a request on the rising edge where valid && ready; requester holds valid/rd/data stable until accepted.
REQ-011 SHALL assert at most one of a_ready/b_ready per cycle; ready is combinational from valids and arbiter state, never asserted without matching valid.
REQ-012 SHALL present an accepted request on reg_write/rd/reg_in in the cycle after acceptance, for exactly one cycle (latency 1).
REQ-013 SHALL hold reg_write=0, rd=0, reg_in=0 in any cycle following a cycle without acceptance.
REQ-014 SHALL accept requests with rd==0 normally but drive reg_write=0, rd=0, reg_in=0 for them (zero register never written).
REQ-015 SHALL sustain one acceptance per cycle with no bubble when a valid is continuously present.
REQ-016 Default arbitration: A wins when both valid, unless wait_cnt==STARVE_MAX, then B wins.
REQ-017 wait_cnt (4-bit) SHALL increment each cycle b_valid && !b_ready, saturate at STARVE_MAX, clear to 0 on B acceptance or b_valid low.
REQ-018 b_starved SHALL equal (wait_cnt==STARVE_MAX), registered.
REQ-019 Only A valid -> grant A; only B valid -> grant B regardless of counter.
REQ-020 Both valid with equal rd SHALL commit in acceptance order; no merging, no drop.
REQ-021 Write-after-write to the same rd from consecutive acceptances SHALL appear in acceptance order on consecutive cycles.

Reset
REQ-022 reset_n low SHALL immediately clear reg_write, rd, reg_in, b_starved, wait_cnt, round-robin pointer to 0, asynchronously.
REQ-023 While reset_n low, a_ready and b_ready SHALL be 0.
REQ-024 A registered write in flight when reset asserts SHALL be discarded (never reaches reg_write=1).
REQ-025 First acceptance possible on the first posedge with reset_n high.

Configuration
REQ-026 Macro WBARB_ROUND_ROBIN_EN defined: arbitration SHALL be round-robin; when both valid, grant the requester not granted last (pointer reset value favours A); wait_cnt removed, b_starved tied 0.
REQ-027 Macro undefined: fixed priority with starvation guard per REQ-016..REQ-018.
REQ-028 Handshake, latency, rd==0 and reset behaviour SHALL be identical in both builds.

Verification
REQ-029 A only: a_valid=1, a_rd=5, a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle reg_write=1, rd=5, reg_in=0xDEADBEEF.
REQ-030 Both valid continuously, STARVE_MAX=4, default build -> A granted 4 cycles, b_starved=1, 5th grant B, wait_cnt cleared, pattern repeats.
REQ-031 Both valid, WBARB_ROUND_ROBIN_EN -> grants alternate A,B,A,B from reset; b_starved stays 0.
REQ-032 B request rd=0, data=0x1234 -> b_ready=1; next cycle reg_write=0, rd=0, reg_in=0.
REQ-033 Accept A (rd=7) then assert reset_n=0 mid-cycle -> reg_write, rd, reg_in drop to 0 immediately; no write of rd=7 after release.
REQ-034 Both valid with a_rd=b_rd=3, data 0x1/0x2, default build -> reg_in 0x1 then later 0x2 on rd=3, no request lost.
